// File: rtl/icache_rsp_pkg.sv
// icache_rsp_pkg: shared bus widths, fsm states and address-split helpers
package icache_rsp_pkg;
  localparam int CacheAddrBus = 25;
  localparam int CacheDataBus = 32;
  localparam int CacheByteBus = 4;
  typedef enum logic [1:0] {IDLE, FILL, RESP} state_t;
  function automatic int off_w(input int line_words);
    return $clog2(line_words);
  endfunction
  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction
  function automatic int tag_w(input int addr_w, input int line_words, input int sets);
    return addr_w - $clog2(line_words) - $clog2(sets);
  endfunction
endpackage

// File: rtl/icache_rsp_refill.sv
// icache_rsp_refill: memory-side word issue and return counting for one line fill
module icache_rsp_refill
  import icache_rsp_pkg::*;
#(
  parameter int ADDR_W = CacheAddrBus,
  parameter int LINE_WORDS = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            active,
  input  logic [ADDR_W-1:0]               base,
  input  logic                            i_m_readdata_valid,
  input  logic                            i_m_waitrequest,
  output logic [ADDR_W-1:0]               o_m_addr,
  output logic                            o_m_read,
  output logic                            we,
  output logic [off_w(LINE_WORDS)-1:0]    wcnt,
  output logic                            line_done
);
  localparam int OFF_W = off_w(LINE_WORDS);
  logic [OFF_W-1:0] issue_cnt;
  assign we = active && i_m_readdata_valid;
  assign line_done = we && wcnt == OFF_W'(LINE_WORDS - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      o_m_read <= 1'b0;
      o_m_addr <= '0;
      issue_cnt <= '0;
      wcnt <= '0;
    end else if (start) begin
      o_m_read <= 1'b1;
      o_m_addr <= base;
      issue_cnt <= '0;
      wcnt <= '0;
    end else begin
      if (o_m_read && !i_m_waitrequest) begin
        issue_cnt <= issue_cnt + 1'b1;
        o_m_read <= issue_cnt != OFF_W'(LINE_WORDS - 1);
        o_m_addr <= {o_m_addr[ADDR_W-1:OFF_W], OFF_W'(issue_cnt + 1'b1)};
      end
      if (we) wcnt <= wcnt + 1'b1;
    end
  end
endmodule

// File: rtl/icache_rsp.sv
// icache_rsp: direct-mapped read-only instruction cache with single-line refill
module icache_rsp
  import icache_rsp_pkg::*;
#(
  parameter int ADDR_W = CacheAddrBus,
  parameter int DATA_W = CacheDataBus,
  parameter int LINE_WORDS = 4,
  parameter int SETS = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_W-1:0]       i_p_addr,
  input  logic [CacheByteBus-1:0] i_p_byte_en,
  input  logic [DATA_W-1:0]       i_p_writedata,
  input  logic                    i_p_read,
  input  logic                    i_p_write,
  output logic [DATA_W-1:0]       o_p_readdata,
  output logic                    o_p_readdata_valid,
  output logic                    o_p_waitrequest,
  input  logic                    i_flush,
  output logic [ADDR_W-1:0]       o_m_addr,
  output logic                    o_m_read,
  input  logic [DATA_W-1:0]       i_m_readdata,
  input  logic                    i_m_readdata_valid,
  input  logic                    i_m_waitrequest
);
  localparam int OFF_W = off_w(LINE_WORDS);
  localparam int IDX_W = idx_w(SETS);
  localparam int TAG_W = tag_w(ADDR_W, LINE_WORDS, SETS);
  state_t state;
  logic [ADDR_W-1:0] req_addr;
  logic req_pend, flush_seen, hit, miss, accept, we, line_done;
  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] req_idx;
  logic [OFF_W-1:0] req_off, wcnt;
  logic [TAG_W-1:0] tags [SETS];
  logic [SETS-1:0] valid;
  logic [DATA_W-1:0] mem [SETS*LINE_WORDS];
  logic unused_ok;
  assign unused_ok = ^{i_p_byte_en, i_p_writedata, i_p_write};
  assign {req_tag, req_idx, req_off} = req_addr;
  assign hit = valid[req_idx] && tags[req_idx] == req_tag;
  assign miss = state == IDLE && req_pend && !hit;
  assign o_p_waitrequest = state != IDLE || (req_pend && !hit);
  assign accept = i_p_read && !o_p_waitrequest;
  assign o_p_readdata_valid = (state == IDLE && req_pend && hit) || state == RESP;
  assign o_p_readdata = o_p_readdata_valid ? mem[{req_idx, req_off}] : '0;
  icache_rsp_refill #(.ADDR_W(ADDR_W), .LINE_WORDS(LINE_WORDS)) u_refill (
    .clk(clk),
    .rst(rst),
    .start(miss),
    .active(state == FILL),
    .base({req_tag, req_idx, OFF_W'(0)}),
    .i_m_readdata_valid(i_m_readdata_valid),
    .i_m_waitrequest(i_m_waitrequest),
    .o_m_addr(o_m_addr),
    .o_m_read(o_m_read),
    .we(we),
    .wcnt(wcnt),
    .line_done(line_done)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      req_pend <= 1'b0;
      req_addr <= '0;
      flush_seen <= 1'b0;
      valid <= '0;
    end else begin
      state <= state == IDLE ? (miss ? FILL : IDLE) : state == FILL ? (line_done ? RESP : FILL) : IDLE;
      req_pend <= accept;
      if (accept) req_addr <= i_p_addr;
      flush_seen <= state == FILL && (flush_seen || i_flush);
      if (i_flush && state != FILL) valid <= '0;
      if (line_done) valid[req_idx] <= !(flush_seen || i_flush);
    end
  end
  always_ff @(posedge clk) begin
    if (we) mem[{req_idx, wcnt}] <= i_m_readdata;
    if (line_done) tags[req_idx] <= req_tag;
  end
endmodule

// File: tb/tb_icache_rsp.sv
// tb_icache_rsp: directed vector and sequence checks for the instruction cache
module tb_icache_rsp;
  localparam int LAT = 2;
  localparam int LW = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic [24:0] p_addr = '0;
  logic [3:0] p_be = 4'hF;
  logic [31:0] p_wdata = '1;
  logic p_read = 1'b0, p_write = 1'b0, fl = 1'b0;
  logic [31:0] p_rdata;
  logic p_valid, p_wait;
  logic [24:0] m_addr;
  logic m_read, m_rvalid, m_wait = 1'b0;
  logic [31:0] m_rdata, mdl_data = '0;
  logic mdl_valid = 1'b0, spur = 1'b0, stall = 1'b0;
  int cyc = 0, vecs = 0, errs = 0, stall_cnt = 0, ret_seen = 0;
  typedef struct {logic [24:0] a; int due;} mreq_t;
  mreq_t q[$];
  logic [24:0] issued[$];
  typedef struct {logic rd; logic wr; logic fl; logic [24:0] a; logic ev; logic ew; logic [31:0] ed;} vec_t;
  vec_t tbl[10];

  icache_rsp dut (
    .clk(clk), .rst(rst),
    .i_p_addr(p_addr), .i_p_byte_en(p_be), .i_p_writedata(p_wdata),
    .i_p_read(p_read), .i_p_write(p_write),
    .o_p_readdata(p_rdata), .o_p_readdata_valid(p_valid), .o_p_waitrequest(p_wait),
    .i_flush(fl),
    .o_m_addr(m_addr), .o_m_read(m_read),
    .i_m_readdata(m_rdata), .i_m_readdata_valid(m_rvalid), .i_m_waitrequest(m_wait)
  );

  assign m_rdata = spur ? 32'hDEADBEEF : mdl_data;
  assign m_rvalid = spur | mdl_valid;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mimg(input logic [24:0] a);
    return {7'h5A, a};
  endfunction

  always @(negedge clk) begin
    m_wait = stall && m_read && stall_cnt < 3;
    if (!m_read) stall_cnt = 0;
    else if (m_wait) stall_cnt = stall_cnt + 1;
    else stall_cnt = 0;
    if (m_read && !m_wait) begin
      q.push_back('{a: m_addr, due: cyc + LAT});
      issued.push_back(m_addr);
    end
    mdl_valid = 1'b0;
    if (q.size() > 0 && q[0].due == cyc) begin
      mdl_valid = 1'b1;
      mdl_data = mimg(q[0].a);
      void'(q.pop_front());
      ret_seen = ret_seen + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic wait_resp(input int t0, input int flush_at, input int exp_lat, input logic [31:0] exp_d);
    bit got = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      fl = (cyc - t0 == flush_at);
      #1;
      if (p_valid) begin
        got = 1'b1;
        chk("miss_latency", cyc - t0, exp_lat);
        chk("miss_data", p_rdata, exp_d);
        chk("resp_wait", 32'(p_wait), 32'd1);
      end
    end
    fl = 1'b0;
    if (!got) chk("resp_timeout", 32'd0, 32'd1);
    @(negedge clk);
    #1;
    chk("post_resp_wait", 32'(p_wait), 32'd0);
    chk("post_resp_valid", 32'(p_valid), 32'd0);
  endtask

  task automatic do_read(input logic [24:0] a, input int flush_at, input int exp_lat);
    int t0;
    issued.delete();
    @(negedge clk);
    p_read = 1'b1;
    p_addr = a;
    t0 = cyc;
    #1;
    chk("accept_wait", 32'(p_wait), 32'd0);
    @(negedge clk);
    p_read = 1'b0;
    #1;
    chk("miss_wait", 32'(p_wait), 32'd1);
    chk("miss_valid", 32'(p_valid), 32'd0);
    wait_resp(t0, flush_at, exp_lat, mimg(a));
    chk("issued_count", 32'(issued.size()), LW);
    foreach (issued[i]) chk("issued_addr", 32'(issued[i]), 32'({a[24:2], 2'b00}) + i);
  endtask

  initial begin
    int t8, base;
    t8 = 0;
    tbl[0] = '{1'b1, 1'b0, 1'b0, 25'h11, 1'b0, 1'b0, 32'h0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 25'h12, 1'b1, 1'b0, mimg(25'h11)};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 25'h13, 1'b1, 1'b0, mimg(25'h12)};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 25'h11, 1'b1, 1'b0, mimg(25'h13)};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 25'h11, 1'b0, 1'b0, 32'h0};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 25'h10, 1'b1, 1'b0, mimg(25'h11)};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 25'h13, 1'b1, 1'b0, mimg(25'h10)};
    tbl[7] = '{1'b0, 1'b0, 1'b1, 25'h13, 1'b1, 1'b0, mimg(25'h13)};
    tbl[8] = '{1'b1, 1'b0, 1'b0, 25'h11, 1'b0, 1'b0, 32'h0};
    tbl[9] = '{1'b0, 1'b0, 1'b0, 25'h11, 1'b0, 1'b1, 32'h0};
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rdata", p_rdata, 32'h0);
    chk("rst_valid", 32'(p_valid), 32'd0);
    chk("rst_wait", 32'(p_wait), 32'd0);
    chk("rst_m_read", 32'(m_read), 32'd0);
    chk("rst_m_addr", 32'(m_addr), 32'd0);
    rst = 1'b0;
    do_read(25'h10, -1, 8);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      p_read = tbl[i].rd;
      p_write = tbl[i].wr;
      fl = tbl[i].fl;
      p_addr = tbl[i].a;
      if (i == 8) t8 = cyc;
      #1;
      chk($sformatf("vec%0d_valid", i), 32'(p_valid), 32'(tbl[i].ev));
      chk($sformatf("vec%0d_wait", i), 32'(p_wait), 32'(tbl[i].ew));
      if (tbl[i].ev) chk($sformatf("vec%0d_data", i), p_rdata, tbl[i].ed);
    end
    p_read = 1'b0;
    p_write = 1'b0;
    fl = 1'b0;
    wait_resp(t8, -1, 8, mimg(25'h11));
    do_read(25'h110, -1, 8);
    do_read(25'h10, -1, 8);
    do_read(25'h20, 3, 8);
    do_read(25'h20, -1, 8);
    @(negedge clk);
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    p_read = 1'b1;
    p_addr = 25'h20;
    @(negedge clk);
    p_read = 1'b0;
    #1;
    chk("spur_valid", 32'(p_valid), 32'd1);
    chk("spur_data", p_rdata, mimg(25'h20));
    chk("spur_wait", 32'(p_wait), 32'd0);
    stall = 1'b1;
    base = ret_seen;
    @(negedge clk);
    p_read = 1'b1;
    p_addr = 25'h30;
    @(negedge clk);
    p_read = 1'b0;
    for (int k = 0; k < 100 && ret_seen < base + 2; k++) begin
      @(negedge clk);
      #1;
    end
    chk("rst_two_returns", ret_seen - base, 32'd2);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midfill_m_read", 32'(m_read), 32'd0);
    chk("midfill_valid", 32'(p_valid), 32'd0);
    chk("midfill_wait", 32'(p_wait), 32'd0);
    do_read(25'h10, -1, 20);
    stall = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
